// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, stall/reset encodings and fetch FSM states
package if_fetch_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0] inst_t;
  localparam inst_t ZERO_WORD = '0;
  localparam inst_addr_t ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
endpackage

// File: rtl/if_fetch_next_pc.sv
// if_next_pc: redirect priority mux choosing the pc that follows the one being fetched
module if_next_pc import if_fetch_pkg::*; #(
  parameter int PC_STEP = 4
) (
  input  logic       flush,
  input  inst_addr_t new_pc,
  input  logic       branch_flag,
  input  inst_addr_t branch_target_address,
  input  logic       pend_valid,
  input  inst_addr_t pend_target,
  input  inst_addr_t pc,
  output inst_addr_t next_pc
);
  assign next_pc = ALIGN_MASK & (flush ? new_pc :
                                 branch_flag ? branch_target_address :
                                 pend_valid ? pend_target : pc + 32'(PC_STEP));
endmodule

// File: rtl/if_fetch.sv
// if_fetch: stage-0 fetch owning the PC, req/ack handshake to instruction memory
module if_fetch import if_fetch_pkg::*; #(
  parameter inst_addr_t RESET_PC = 32'h0000_0000,
  parameter int PC_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  input  logic       flush,
  input  inst_addr_t new_pc,
  input  logic       branch_flag,
  input  inst_addr_t branch_target_address,
  output logic       inst_req,
  output inst_addr_t inst_addr,
  input  logic       inst_ack,
  input  inst_t      inst_rdata,
  output inst_addr_t if_pc,
  output inst_t      if_inst,
  output logic       stallreq_if
);
  logic [1:0] state;
  inst_addr_t pc, pend_target, next_pc;
  inst_t buf_data;
  logic buf_valid, pend_valid, have, adv, unused_stall;
  assign unused_stall = ^stall[5:1];
  assign have = (state == S_FETCH && inst_ack) || (state == S_HOLD && buf_valid);
  assign adv = have && stall[0] == NO_STOP && !flush;
  assign stallreq_if = (state == S_DRAIN) || (inst_req && !inst_ack);
  if_next_pc #(.PC_STEP(PC_STEP)) u_next_pc (
    .flush(flush),
    .new_pc(new_pc),
    .branch_flag(branch_flag),
    .branch_target_address(branch_target_address),
    .pend_valid(pend_valid),
    .pend_target(pend_target),
    .pc(pc),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      pc <= RESET_PC & ALIGN_MASK;
      state <= S_IDLE;
      inst_req <= 1'b0;
      inst_addr <= ZERO_WORD;
      if_pc <= ZERO_WORD;
      if_inst <= ZERO_WORD;
      buf_valid <= 1'b0;
      buf_data <= ZERO_WORD;
      pend_valid <= 1'b0;
      pend_target <= ZERO_WORD;
    end else if (flush) begin
      // an unacked request must still complete, so drain it before refetching
      pc <= next_pc;
      if_pc <= ZERO_WORD;
      if_inst <= ZERO_WORD;
      buf_valid <= 1'b0;
      pend_valid <= 1'b0;
      inst_req <= 1'b1;
      state <= (inst_req && !inst_ack) ? S_DRAIN : S_FETCH;
      inst_addr <= (inst_req && !inst_ack) ? inst_addr : next_pc;
    end else begin
      if (branch_flag && !adv) begin
        pend_valid <= 1'b1;
        pend_target <= branch_target_address;
      end
      if (adv) begin
        if_pc <= pc;
        if_inst <= (state == S_HOLD) ? buf_data : inst_rdata;
        pc <= next_pc;
        inst_addr <= next_pc;
        inst_req <= 1'b1;
        buf_valid <= 1'b0;
        pend_valid <= 1'b0;
        state <= S_FETCH;
      end else if (state == S_IDLE) begin
        state <= S_FETCH;
        inst_req <= 1'b1;
        inst_addr <= pc;
      end else if (state == S_FETCH && inst_ack && stall[0] == STOP) begin
        buf_valid <= 1'b1;
        buf_data <= inst_rdata;
        inst_req <= 1'b0;
        state <= S_HOLD;
      end else if (state == S_DRAIN && inst_ack) begin
        inst_addr <= pc;
        state <= S_FETCH;
      end
    end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Stage-0 fetch unit directly upstream of the IF/ID pipeline register. It owns the PC and runs a req/ack handshake to instruction memory with variable wait states. It presents if_pc/if_inst to IF/ID and raises a stall request to ctrl while memory is slow. PC redirects come from ID (branch/jump with delay slot) and from ctrl (exception flush).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (rst==0 resets)
stall  in  6  ctrl stall vector; bit0 = PC/fetch stage, `Stop=1
flush  in  1  ctrl exception flush; highest-priority redirect
new_pc  in  32  flush target (exception vector / EPC)
branch_flag  in  1  ID: taken branch/jump this cycle
branch_target_address  in  32  ID: redirect target
inst_req  out  1  memory request valid
inst_addr  out  32  memory request address (word aligned)
inst_ack  in  1  memory: inst_rdata valid this cycle, request done
inst_rdata  in  32  fetched instruction
if_pc  out  32  PC of presented instruction (to IF/ID)
if_inst  out  32  presented instruction (to IF/ID)
stallreq_if  out  1  to ctrl: fetch not complete, stall stage 0 and up

Behaviour:
- Reset (rst==0, async): pc=RESET_PC; state=S_IDLE; inst_req=0; inst_addr=0; if_pc=0; if_inst=0; buffer invalid; stallreq_if=0.
- States: S_IDLE, S_FETCH, S_HOLD, S_DRAIN. All outputs except stallreq_if are registered.
- S_IDLE: first edge after reset release -> S_FETCH with inst_req=1, inst_addr=pc.
- S_FETCH: inst_req=1; inst_addr stays stable until inst_ack. stallreq_if = inst_req & ~inst_ack (combinational).
- Advance: on an edge with stall[0]==`NoStop and the instruction for pc available (inst_ack this cycle, or buffer valid):
  - if_pc<=pc; if_inst<=inst (rdata or buffer); pc<=next_pc; buffer cleared; new request for next_pc issued on the same edge (stay S_FETCH).
- Back-to-back fetch: zero-wait memory gives one instruction per cycle.
- Ack while stall[0]==`Stop: capture inst_rdata into the buffer; inst_req<=0; -> S_HOLD. if_pc/if_inst hold.
- S_HOLD: no request. Advance when stall[0] clears, using buffer data -> S_FETCH.
- next_pc priority: flush ? new_pc : branch_flag ? branch_target_address : pc+PC_STEP, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- flush: takes effect regardless of stall:
  - pc<=new_pc; if_pc<=0; if_inst<=0 (bubble to IF/ID); buffer discarded.
  - If a request is outstanding without ack this cycle -> S_DRAIN. Otherwise -> S_FETCH at new_pc.
- branch_flag: the delay slot is the instruction currently being fetched. It completes normally. The pc following it is branch_target_address, so the target is latched as pending_target when the slot is not yet advanced.
- Flush overrides any pending branch target.
- S_DRAIN: keep inst_req=1 on the old address (requests are never abandoned). On inst_ack, discard data, issue new request at pc -> S_FETCH. stallreq_if=1 throughout S_DRAIN.
- Simultaneous ack + flush: data discarded; new fetch at new_pc starts next cycle.
- Simultaneous flush + branch_flag: flush wins; the branch is dropped.
- Reset mid-transaction: everything returns to reset state immediately. The memory must tolerate inst_req dropping without ack.
- inst_addr[1:0] always 0; targets with nonzero low bits are truncated. Alignment exceptions are detected in ID.

Decomposition:
- Shared package/defines: `InstAddrBus, `InstBus, `ZeroWord, `Stop/`NoStop, `RstEnable, and the state encodings for S_IDLE/S_FETCH/S_HOLD/S_DRAIN.
- One sub-module, if_next_pc: combinational redirect priority mux plus pending-target register select.
- Handshake FSM and output registers stay in if_fetch.

Test Plan:
- Reset release, RESET_PC=0, memory acks every cycle -> inst_addr 0,4,8,12 on consecutive cycles; if_pc trails by one; stallreq_if never asserted.
- Memory with 3 wait states -> inst_req/inst_addr stable 4 cycles; stallreq_if=1 for 3 cycles; if_pc advances once per 4 cycles.
- Ack arrives while stall[0]=1 for 2 cycles -> inst_req drops, buffer holds data; on release if_inst=buffered word with no new memory access for it; next request at pc+4.
- branch_flag with target 32'h0000_0100 while delay slot at 0x14 in flight -> if_pc sequence ...,0x14,0x100.
- flush with new_pc=32'hBFC0_0380 during an outstanding request -> if_inst=0, S_DRAIN until ack; old data discarded; next inst_addr=32'hBFC0_0380.
- rst pulled low mid-wait, then released -> all outputs 0 immediately; first inst_addr=RESET_PC after release; PC wrap check 0xFFFF_FFFC -> 0.
